// File: rtl/wb_regfile.sv
// Writeback-side architectural state: 32x32 GPR file plus HI/LO, with same-cycle
// write-to-read bypass so ID/EX never see stale data from the instruction in WB.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              whilo,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [CNT_W-1:0]  wr_cnt
);

  logic [DATA_W-1:0] gpr_q [NREG];
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gpr_wr;

  // r0 is hardwired to zero, so writes to it are neither stored nor counted
  assign gpr_wr = we && (waddr != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (gpr_wr) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (whilo) begin
      hi_d = hi_i;
      lo_d = lo_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (gpr_wr) gpr_q[waddr] <= wdata;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (!rst && re1 && (raddr1 != '0)) begin
      if (we && (waddr == raddr1)) rdata1 = wdata;
      else                         rdata1 = gpr_q[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (!rst && re2 && (raddr2 != '0)) begin
      if (we && (waddr == raddr2)) rdata2 = wdata;
      else                         rdata2 = gpr_q[raddr2];
    end
  end

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (!rst) begin
      hi_o = whilo ? hi_i : hi_q;
      lo_o = whilo ? lo_i : lo_q;
    end
  end

  assign wr_cnt = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios followed by random
// traffic, all compared against an array-based architectural model.
module tb_wb_regfile;

  localparam int CW = 4;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        whilo;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [CW-1:0] wr_cnt;

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .NREG(32), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .whilo(whilo), .hi_i(hi_i), .lo_i(lo_i),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .hi_o(hi_o), .lo_o(lo_o), .wr_cnt(wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // architectural model
  logic [31:0] gpr_m [32];
  logic [31:0] hi_m, lo_m;
  int          cnt_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] ra);
    if (rst || !re || ra == 5'd0) return 32'h0;
    if (we && waddr == ra) return wdata;
    return gpr_m[ra];
  endfunction

  // compare all outputs against the model for the current inputs, then clock
  task automatic step();
    #2;
    chk("rdata1", rdata1, exp_rd(re1, raddr1));
    chk("rdata2", rdata2, exp_rd(re2, raddr2));
    chk("hi_o", hi_o, rst ? 32'h0 : (whilo ? hi_i : hi_m));
    chk("lo_o", lo_o, rst ? 32'h0 : (whilo ? lo_i : lo_m));
    chk("wr_cnt", {28'h0, wr_cnt}, 32'(cnt_m));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) gpr_m[i] = 32'h0;
      hi_m = 32'h0;
      lo_m = 32'h0;
      cnt_m = 0;
    end else begin
      if (we && waddr != 5'd0) begin
        gpr_m[waddr] = wdata;
        cnt_m = (cnt_m + 1) % (1 << CW);
      end
      if (whilo) begin
        hi_m = hi_i;
        lo_m = lo_i;
      end
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) gpr_m[i] = 32'h0;
    hi_m = 32'h0; lo_m = 32'h0; cnt_m = 0;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; whilo = 1'b0;
    hi_i = '0; lo_i = '0; re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;

    // reset for two cycles, the first before any check since state is unknown
    @(posedge clk); #1;
    step();

    // idle reads after reset
    rst = 1'b0; re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd5; raddr2 = 5'd31;
    #1;
    chk("idle_rd1", rdata1, 32'h0);
    chk("idle_rd2", rdata2, 32'h0);
    chk("idle_hi", hi_o, 32'h0);
    step();

    // write then read back through storage
    we = 1'b1; waddr = 5'd7; wdata = 32'hDEADBEEF;
    step();
    we = 1'b0; raddr1 = 5'd7;
    #1;
    chk("wb_rd1", rdata1, 32'hDEADBEEF);
    chk("wb_cnt", {28'h0, wr_cnt}, 32'd1);
    step();

    // same-cycle bypass on both ports
    we = 1'b1; waddr = 5'd3; wdata = 32'h11;
    step();
    wdata = 32'h22; raddr1 = 5'd3; raddr2 = 5'd3;
    #1;
    chk("byp_rd1", rdata1, 32'h22);
    chk("byp_rd2", rdata2, 32'h22);
    step();
    we = 1'b0;
    #1;
    chk("byp_store", rdata1, 32'h22);
    step();

    // r0 writes are ignored and not counted
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0;
    #1;
    chk("r0_same", rdata1, 32'h0);
    step();
    we = 1'b0;
    #1;
    chk("r0_after", rdata1, 32'h0);
    chk("r0_cnt", {28'h0, wr_cnt}, 32'd3);
    step();

    // HI/LO bypass and hold
    whilo = 1'b1; hi_i = 32'h12345678; lo_i = 32'h9ABCDEF0;
    #1;
    chk("hilo_byp_hi", hi_o, 32'h12345678);
    chk("hilo_byp_lo", lo_o, 32'h9ABCDEF0);
    step();
    whilo = 1'b0; hi_i = 32'h0; lo_i = 32'h0;
    #1;
    chk("hilo_hold_hi", hi_o, 32'h12345678);
    chk("hilo_hold_lo", lo_o, 32'h9ABCDEF0);
    step();

    // read enable gating
    re1 = 1'b0; raddr1 = 5'd7;
    #1;
    chk("re_gate", rdata1, 32'h0);
    step();

    // reset mid-stream swallows the concurrent write
    rst = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h55; re1 = 1'b1; whilo = 1'b1;
    hi_i = 32'hA5A5A5A5;
    #1;
    chk("rst_force_rd", rdata1, 32'h0);
    chk("rst_force_hi", hi_o, 32'h0);
    step();
    rst = 1'b0; we = 1'b0; whilo = 1'b0; raddr1 = 5'd9; raddr2 = 5'd7;
    #1;
    chk("rst_r9", rdata1, 32'h0);
    chk("rst_r7", rdata2, 32'h0);
    chk("rst_cnt", {28'h0, wr_cnt}, 32'd0);
    step();

    // counter wrap: 17 writes at 4-bit width leaves 1
    for (int i = 0; i < 17; i++) begin
      we = 1'b1; waddr = 5'(1 + (i % 31)); wdata = $urandom;
      step();
    end
    we = 1'b0;
    #1;
    chk("cnt_wrap", {28'h0, wr_cnt}, 32'd1);
    step();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rst    = ($urandom_range(0, 49) == 0);
      we     = $urandom_range(0, 1);
      waddr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      wdata  = $urandom;
      whilo  = ($urandom_range(0, 3) == 0);
      hi_i   = $urandom;
      lo_i   = $urandom;
      re1    = ($urandom_range(0, 7) != 0);
      re2    = ($urandom_range(0, 7) != 0);
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
